// File: rtl/ex_pkg.sv
// Shared types for the execute sequencer: op classes, jump conditions,
// FSM states, flag bit positions and functional-unit strobe positions.
package ex_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_IALU  = 3'd1,
        OP_VALU  = 3'd2,
        OP_ISWAP = 3'd3,
        OP_VSWAP = 3'd4,
        OP_MEM   = 3'd5,
        OP_JUMP  = 3'd6,
        OP_END   = 3'd7
    } op_class_e;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_Z      = 2'b01,
        COND_NZ     = 2'b10,
        COND_NXV    = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_VALU_WAIT = 2'd1,
        ST_MEM_WAIT  = 2'd2,
        ST_HALT      = 2'd3
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bit positions inside fu_start_o {VSWAP,ISWAP,VALU,IALU,MEM}
    localparam int FU_MEM   = 0;
    localparam int FU_IALU  = 1;
    localparam int FU_VALU  = 2;
    localparam int FU_ISWAP = 3;
    localparam int FU_VSWAP = 4;

endpackage

// File: rtl/ex_sequencer_if.sv
// Issue / functional-unit / writeback bundle between the decoder side and
// the execute sequencer.
interface ex_sequencer_if #(
    parameter int CNT_BITS = 16
);
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [2:0]          op_class_i;
    logic [1:0]          cond_i;
    logic [9:0]          jump_addr_i;
    logic [3:0]          alu_flags_i;
    logic                mem_ack_i;
    logic                mem_req_o;
    logic [4:0]          fu_start_o;
    logic                wb_valid_o;
    logic [2:0]          wb_sel_o;
    logic                branch_taken_o;
    logic [9:0]          branch_addr_o;
    logic                halted_o;
    logic [CNT_BITS-1:0] retired_o;

    modport master (
        output issue_valid_i, op_class_i, cond_i, jump_addr_i, alu_flags_i, mem_ack_i,
        input  issue_ready_o, mem_req_o, fu_start_o, wb_valid_o, wb_sel_o,
               branch_taken_o, branch_addr_o, halted_o, retired_o
    );

    modport slave (
        input  issue_valid_i, op_class_i, cond_i, jump_addr_i, alu_flags_i, mem_ack_i,
        output issue_ready_o, mem_req_o, fu_start_o, wb_valid_o, wb_sel_o,
               branch_taken_o, branch_addr_o, halted_o, retired_o
    );
endinterface

// File: rtl/ex_cond_eval.sv
// Combinational jump-condition evaluator: decides whether a JUMP is taken
// from its condition code and the current {N,Z,C,V} flags.
module ex_cond_eval
    import ex_pkg::*;
(
    input  cond_e      cond_i,
    input  logic [3:0] flags_i,
    output logic       taken_o
);
    // Carry takes part in no condition; the name keeps it out of unused warnings.
    logic unused_flag_c;
    assign unused_flag_c = flags_i[FLAG_C];

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_ALWAYS: taken_o = 1'b1;
            COND_Z:      taken_o = flags_i[FLAG_Z];
            COND_NZ:     taken_o = ~flags_i[FLAG_Z];
            COND_NXV:    taken_o = flags_i[FLAG_N] ^ flags_i[FLAG_V];
            default:     taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/ex_sequencer.sv
// Single-issue execute sequencer: accepts one decoded op at a time, launches
// the functional unit, and reports writeback, branches, halt and retire count.
module ex_sequencer
    import ex_pkg::*;
#(
    parameter int VALU_LAT = 2,
    parameter int CNT_BITS = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ex_sequencer_if.slave  bus
);
    localparam logic [3:0] LAT_M1 = 4'(VALU_LAT - 1);

    state_e              state_q, state_d;
    logic [3:0]          lat_cnt_q, lat_cnt_d;
    logic [3:0]          flags_q, flags_d;
    logic                wb_valid_q, wb_valid_d;
    logic [2:0]          wb_sel_q, wb_sel_d;
    logic                br_taken_q, br_taken_d;
    logic [9:0]          br_addr_q, br_addr_d;
    logic [CNT_BITS-1:0] retired_q, retired_d;

    op_class_e           op;
    logic                ready;
    logic                accept;
    logic                retire;
    logic                cond_taken;
    logic [4:0]          fu_start;

    assign op = op_class_e'(bus.op_class_i);

    ex_cond_eval u_cond_eval (
        .cond_i  (cond_e'(bus.cond_i)),
        .flags_i (flags_q),
        .taken_o (cond_taken)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= '0;
            flags_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_sel_q   <= '0;
            br_taken_q <= 1'b0;
            br_addr_q  <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            flags_q    <= flags_d;
            wb_valid_q <= wb_valid_d;
            wb_sel_q   <= wb_sel_d;
            br_taken_q <= br_taken_d;
            br_addr_q  <= br_addr_d;
            retired_q  <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        flags_d    = flags_q;
        wb_valid_d = 1'b0;
        wb_sel_d   = '0;
        br_taken_d = 1'b0;
        br_addr_d  = br_addr_q;
        retire     = 1'b0;
        fu_start   = '0;
        // Ready is gated by reset so every output reads zero while held in reset.
        ready      = rst_i && (state_q == ST_IDLE) && !br_taken_q;
        accept     = ready && bus.issue_valid_i;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_IALU: begin
                            fu_start[FU_IALU] = 1'b1;
                            flags_d           = bus.alu_flags_i;
                            wb_valid_d        = 1'b1;
                            wb_sel_d          = op;
                        end
                        OP_ISWAP: begin
                            fu_start[FU_ISWAP] = 1'b1;
                            wb_valid_d         = 1'b1;
                            wb_sel_d           = op;
                        end
                        OP_VSWAP: begin
                            fu_start[FU_VSWAP] = 1'b1;
                            wb_valid_d         = 1'b1;
                            wb_sel_d           = op;
                        end
                        OP_VALU: begin
                            fu_start[FU_VALU] = 1'b1;
                            if (VALU_LAT <= 1) begin
                                wb_valid_d = 1'b1;
                                wb_sel_d   = op;
                            end else begin
                                state_d   = ST_VALU_WAIT;
                                lat_cnt_d = LAT_M1;
                            end
                        end
                        OP_MEM: begin
                            fu_start[FU_MEM] = 1'b1;
                            state_d          = ST_MEM_WAIT;
                        end
                        OP_JUMP: begin
                            retire = 1'b1;
                            if (cond_taken) begin
                                br_taken_d = 1'b1;
                                br_addr_d  = bus.jump_addr_i;
                            end
                        end
                        OP_END: begin
                            retire  = 1'b1;
                            state_d = ST_HALT;
                        end
                        default: ;
                    endcase
                end
            end
            ST_VALU_WAIT: begin
                // Final wait cycle: writeback lands as the FSM reenters IDLE.
                if (lat_cnt_q <= 4'd1) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_sel_d   = OP_VALU;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ack_i) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_sel_d   = OP_MEM;
                end
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase

        retired_d = retired_q;
        if (wb_valid_d || retire)
            retired_d = retired_q + CNT_BITS'(1);
    end

    assign bus.issue_ready_o  = ready;
    assign bus.fu_start_o     = fu_start;
    assign bus.mem_req_o      = (state_q == ST_MEM_WAIT);
    assign bus.wb_valid_o     = wb_valid_q;
    assign bus.wb_sel_o       = wb_sel_q;
    assign bus.branch_taken_o = br_taken_q;
    assign bus.branch_addr_o  = br_addr_q;
    assign bus.halted_o       = (state_q == ST_HALT);
    assign bus.retired_o      = retired_q;
endmodule

// File: tb/tb_ex_sequencer.sv
// Scoreboard bench for ex_sequencer: expected writebacks/branches are queued at
// issue time and popped by a monitor when the sequencer reports them.
module tb_ex_sequencer;
    localparam int VALU_LAT = 3;
    localparam int CNT_BITS = 16;

    logic clk_i;
    logic rst_i;

    ex_sequencer_if #(.CNT_BITS(CNT_BITS)) bus ();

    ex_sequencer #(.VALU_LAT(VALU_LAT), .CNT_BITS(CNT_BITS)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0]          exp_wb[$];
    logic [9:0]          exp_br[$];
    logic [3:0]          flags_m;
    logic [CNT_BITS-1:0] ret_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic cond_ok(input logic [1:0] c, input logic [3:0] f);
        case (c)
            2'b00:   return 1'b1;
            2'b01:   return f[2];
            2'b10:   return !f[2];
            default: return f[3] ^ f[0];
        endcase
    endfunction

    function automatic logic [4:0] fu_exp(input logic [2:0] cls);
        case (cls)
            3'd5:    return 5'b00001;
            3'd1:    return 5'b00010;
            3'd2:    return 5'b00100;
            3'd3:    return 5'b01000;
            3'd4:    return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    // Monitor: every writeback / branch must match the head of its queue.
    always @(negedge clk_i) begin
        if (bus.wb_valid_o) begin
            if (exp_wb.size() == 0) check("wb_unexpected", 1, 0);
            else check("wb_sel", bus.wb_sel_o, exp_wb.pop_front());
        end
        if (bus.branch_taken_o) begin
            if (exp_br.size() == 0) check("br_unexpected", 1, 0);
            else check("br_addr", bus.branch_addr_o, exp_br.pop_front());
        end
        if (bus.wb_valid_o && bus.branch_taken_o) check("wb_br_exclusive", 1, 0);
    end

    // Called at a falling edge; returns at the falling edge of the cycle after accept.
    task automatic issue(input logic [2:0] cls, input logic [1:0] c,
                         input logic [9:0] a, input logic [3:0] f);
        int n;
        n = 0;
        while (!bus.issue_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!bus.issue_ready_o) begin
            check("ready_timeout", 0, 1);
            return;
        end
        bus.issue_valid_i = 1'b1;
        bus.op_class_i    = cls;
        bus.cond_i        = c;
        bus.jump_addr_i   = a;
        bus.alu_flags_i   = f;
        case (cls)
            3'd1: begin flags_m = f; exp_wb.push_back(cls); ret_m++; end
            3'd2, 3'd3, 3'd4, 3'd5: begin exp_wb.push_back(cls); ret_m++; end
            3'd6: begin
                if (cond_ok(c, flags_m)) exp_br.push_back(a);
                ret_m++;
            end
            3'd7: ret_m++;
            default: ;
        endcase
        #1;
        check("fu_start", bus.fu_start_o, fu_exp(cls));
        @(negedge clk_i);
        bus.issue_valid_i = 1'b0;
        bus.op_class_i    = 3'd0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        exp_wb.delete();
        exp_br.delete();
        flags_m = '0;
        ret_m   = '0;
        #1;
        check("rst_ready", bus.issue_ready_o, 0);
        check("rst_retired", bus.retired_o, 0);
        check("rst_halted", bus.halted_o, 0);
        check("rst_mem_req", bus.mem_req_o, 0);
        check("rst_wb", bus.wb_valid_o, 0);
        check("rst_br_addr", bus.branch_addr_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("post_rst_ready", bus.issue_ready_o, 1);
    endtask

    initial begin
        bus.issue_valid_i = 1'b0;
        bus.op_class_i    = '0;
        bus.cond_i        = '0;
        bus.jump_addr_i   = '0;
        bus.alu_flags_i   = '0;
        bus.mem_ack_i     = 1'b0;
        flags_m           = '0;
        ret_m             = '0;
        rst_i             = 1'b1;
        #2;
        do_reset();
        @(negedge clk_i);

        // IALU sets Z, JUMP on Z taken
        issue(3'd1, 2'b00, 10'h000, 4'b0100);
        check("ialu_wb_t1", bus.wb_valid_o, 1);
        issue(3'd6, 2'b01, 10'h2A5, 4'b0000);
        check("jmp_taken", bus.branch_taken_o, 1);
        check("jmp_addr", bus.branch_addr_o, 10'h2A5);
        check("jmp_no_wb", bus.wb_valid_o, 0);
        check("jmp_ready_low", bus.issue_ready_o, 0);
        check("retired_2", bus.retired_o, 2);
        @(negedge clk_i);

        // JUMP on Z=0 with Z set: not taken
        issue(3'd6, 2'b10, 10'h155, 4'b0000);
        check("jnz_not_taken", bus.branch_taken_o, 0);
        check("jnz_ready", bus.issue_ready_o, 1);
        check("retired_3", bus.retired_o, 3);

        // N xor V conditions
        issue(3'd1, 2'b00, 10'h000, 4'b1000);
        issue(3'd6, 2'b11, 10'h3FF, 4'b0000);
        check("jnv_taken", bus.branch_taken_o, 1);
        @(negedge clk_i);
        issue(3'd1, 2'b00, 10'h000, 4'b1001);
        issue(3'd6, 2'b11, 10'h001, 4'b0000);
        check("jnv_not_taken", bus.branch_taken_o, 0);
        check("retired_model_a", bus.retired_o, ret_m);

        // VALU latency 3, then back-to-back op at T+3
        issue(3'd2, 2'b00, 10'h000, 4'b0000);
        check("valu_rdy_t1", bus.issue_ready_o, 0);
        @(negedge clk_i);
        check("valu_rdy_t2", bus.issue_ready_o, 0);
        check("valu_wb_t2", bus.wb_valid_o, 0);
        @(negedge clk_i);
        check("valu_wb_t3", bus.wb_valid_o, 1);
        check("valu_sel_t3", bus.wb_sel_o, 2);
        check("valu_rdy_t3", bus.issue_ready_o, 1);
        issue(3'd3, 2'b00, 10'h000, 4'b0000);
        check("iswap_wb", bus.wb_valid_o, 1);

        // Spurious acks in IDLE
        bus.mem_ack_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            check("spur_ack_req", bus.mem_req_o, 0);
            check("spur_ack_wb", bus.wb_valid_o, 0);
        end
        bus.mem_ack_i = 1'b0;

        // MEM with ack in the fifth request cycle
        issue(3'd5, 2'b00, 10'h000, 4'b0000);
        for (int i = 1; i <= 5; i++) begin
            check("mem_req_hi", bus.mem_req_o, 1);
            check("mem_no_wb", bus.wb_valid_o, 0);
            if (i == 5) bus.mem_ack_i = 1'b1;
            @(negedge clk_i);
        end
        bus.mem_ack_i = 1'b0;
        check("mem_req_drop", bus.mem_req_o, 0);
        check("mem_wb", bus.wb_valid_o, 1);
        @(negedge clk_i);
        check("mem_single_wb", bus.wb_valid_o, 0);

        // NOP and VSWAP
        issue(3'd0, 2'b00, 10'h000, 4'b0000);
        check("nop_no_wb", bus.wb_valid_o, 0);
        issue(3'd4, 2'b00, 10'h000, 4'b0000);
        check("retired_model_b", bus.retired_o, ret_m);

        // END, then keep offering ops
        issue(3'd7, 2'b00, 10'h000, 4'b0000);
        check("end_halted", bus.halted_o, 1);
        check("end_retired", bus.retired_o, ret_m);
        bus.issue_valid_i = 1'b1;
        bus.op_class_i    = 3'd3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check("halt_sticky", bus.halted_o, 1);
            check("halt_ready", bus.issue_ready_o, 0);
            check("halt_fu", bus.fu_start_o, 0);
        end
        bus.issue_valid_i = 1'b0;
        bus.op_class_i    = 3'd0;
        do_reset();
        @(negedge clk_i);

        // Reset in the middle of a VALU
        issue(3'd2, 2'b00, 10'h000, 4'b0000);
        do_reset();
        repeat (5) @(negedge clk_i);
        check("abort_retired", bus.retired_o, 0);
        check("abort_ready", bus.issue_ready_o, 1);

        // Counter wrap
        for (int i = 0; i < 65535; i++) issue(3'd3, 2'b00, 10'h000, 4'b0000);
        check("retired_ffff", bus.retired_o, 16'hFFFF);
        issue(3'd3, 2'b00, 10'h000, 4'b0000);
        check("retired_wrap", bus.retired_o, 0);
        check("retired_model_c", bus.retired_o, ret_m);

        repeat (3) @(negedge clk_i);
        check("wb_queue_empty", exp_wb.size(), 0);
        check("br_queue_empty", exp_br.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
